// File: rtl/axi_wburst_buf_if.sv
// AXI4 write-channel bundle (AW, W, B) between the burst buffer and a slave.
interface axi_wburst_buf_if;
    logic [31:0] M_AXI_AWADDR;
    logic [7:0]  M_AXI_AWLEN;
    logic [2:0]  M_AXI_AWSIZE;
    logic [1:0]  M_AXI_AWBURST;
    logic [2:0]  M_AXI_AWPROT;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [63:0] M_AXI_WDATA;
    logic [7:0]  M_AXI_WSTRB;
    logic        M_AXI_WLAST;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BVALID,
        output M_AXI_BREADY
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BVALID,
        input  M_AXI_BREADY
    );
endinterface

// File: rtl/axi_wburst_buf.sv
// 64-bit FWFT FIFO that drains each committed group of pushed words as one
// AXI4 INCR write burst (AW, then W beats, then wait for B).
module axi_wburst_buf #(
    parameter int DEPTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_req,
    input  logic [63:0] wdata,
    input  logic        write_bus_req,
    input  logic [31:0] address,
    output logic        busy,
    output logic        overflow,
    axi_wburst_buf_if.master m_axi
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t        state, state_nxt;
    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt, beats, in_flight, snap, pend_len;
    logic [31:0]   pend_addr;
    logic          pending, push, pop;

    assign push      = write_req && (count != CW'(DEPTH));
    assign pop       = m_axi.M_AXI_WVALID && m_axi.M_AXI_WREADY;
    assign count_nxt = count + CW'(push) - CW'(pop);

    // Words still owed to the burst in flight are not part of the next burst.
    always_comb begin
        in_flight = '0;
        if (state == ADDR)      in_flight = beats;
        else if (state == DATA) in_flight = beats - CW'(pop);
    end
    assign snap = count_nxt - in_flight;

    assign m_axi.M_AXI_AWSIZE  = 3'b011;
    assign m_axi.M_AXI_AWBURST = 2'b01;
    assign m_axi.M_AXI_AWPROT  = 3'b000;
    assign m_axi.M_AXI_WSTRB   = 8'hFF;
    assign m_axi.M_AXI_WDATA   = mem[rd_ptr];
    assign m_axi.M_AXI_WLAST   = (state == DATA) && (beats == CW'(1));
    assign busy                = (state != IDLE) || pending;

    always_comb begin
        state_nxt            = state;
        m_axi.M_AXI_AWVALID  = 1'b0;
        m_axi.M_AXI_WVALID   = 1'b0;
        m_axi.M_AXI_BREADY   = 1'b0;
        case (state)
            IDLE: if (pending) state_nxt = ADDR;
            ADDR: begin
                m_axi.M_AXI_AWVALID = 1'b1;
                if (m_axi.M_AXI_AWREADY) state_nxt = DATA;
            end
            DATA: begin
                m_axi.M_AXI_WVALID = 1'b1;
                if (m_axi.M_AXI_WREADY && beats == CW'(1)) state_nxt = RESP;
            end
            RESP: begin
                m_axi.M_AXI_BREADY = 1'b1;
                if (m_axi.M_AXI_BVALID) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            count              <= '0;
            beats              <= '0;
            pending            <= 1'b0;
            pend_addr          <= '0;
            pend_len           <= '0;
            overflow           <= 1'b0;
            m_axi.M_AXI_AWADDR <= '0;
            m_axi.M_AXI_AWLEN  <= '0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            overflow <= overflow | (write_req && !push);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                beats  <= beats - CW'(1);
            end
            if (state == IDLE && pending) begin
                pending            <= 1'b0;
                beats              <= pend_len;
                m_axi.M_AXI_AWADDR <= pend_addr;
                m_axi.M_AXI_AWLEN  <= 8'(pend_len - CW'(1));
            end else if (write_bus_req && !pending && snap != '0) begin
                pending   <= 1'b1;
                pend_addr <= address;
                pend_len  <= snap;
            end
        end
    end
endmodule

// File: tb/tb_axi_wburst_buf.sv
// Scoreboard bench for axi_wburst_buf: expected AW/W traffic is queued at
// the burst request and compared as the DUT hands it out.
module tb_axi_wburst_buf;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset, write_req, write_bus_req, busy, overflow;
    logic [63:0] wdata;
    logic [31:0] address;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } aw_exp_t;

    aw_exp_t     aw_q[$];
    logic [64:0] w_q[$];
    logic [63:0] staged[$];
    int          checks = 0, errors = 0, hs_cnt = 0, outstanding = 0;
    bit          tog = 0, stall = 0;
    logic [63:0] s_data;
    logic        s_last;

    axi_wburst_buf_if axi();

    axi_wburst_buf #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .write_req(write_req), .wdata(wdata),
        .write_bus_req(write_bus_req), .address(address),
        .busy(busy), .overflow(overflow), .m_axi(axi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (tog) axi.M_AXI_WREADY = ~axi.M_AXI_WREADY;
    endtask

    // One cycle of stimulus: optional push, optional burst request.
    task automatic step(input bit do_push, input logic [63:0] d, input bit keep,
                        input bit do_req, input logic [31:0] a);
        aw_exp_t e;
        write_req     = do_push;
        wdata         = d;
        write_bus_req = do_req;
        address       = a;
        if (do_push && keep) staged.push_back(d);
        if (do_req && staged.size() != 0) begin
            e.addr = a;
            e.len  = 8'(staged.size() - 1);
            aw_q.push_back(e);
            while (staged.size() != 0) begin
                logic [63:0] w;
                w = staged.pop_front();
                w_q.push_back({staged.size() == 0, w});
            end
        end
        cyc();
        write_req     = 1'b0;
        write_bus_req = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int n = 0;
        while ((busy || aw_q.size() != 0 || w_q.size() != 0) && n < max) begin
            cyc();
            n++;
        end
        if (n >= max) chk("timeout", 0, 1);
        chk("busy_end", busy, 0);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            aw_q.delete();
            w_q.delete();
            outstanding = 0;
            stall = 0;
        end else begin
            if (axi.M_AXI_AWVALID && axi.M_AXI_AWREADY) begin
                chk("aw_after_b", outstanding, 0);
                outstanding++;
                if (aw_q.size() == 0) chk("aw_unexp", 1, 0);
                else begin
                    aw_exp_t e;
                    e = aw_q.pop_front();
                    chk("awaddr", axi.M_AXI_AWADDR, e.addr);
                    chk("awlen", axi.M_AXI_AWLEN, e.len);
                    chk("awsize", axi.M_AXI_AWSIZE, 3'b011);
                end
            end
            if (axi.M_AXI_WVALID) begin
                if (stall) begin
                    chk("w_hold_data", axi.M_AXI_WDATA, s_data);
                    chk("w_hold_last", axi.M_AXI_WLAST, s_last);
                end
                if (axi.M_AXI_WREADY) begin
                    hs_cnt++;
                    if (w_q.size() == 0) chk("w_unexp", 1, 0);
                    else begin
                        logic [64:0] w;
                        w = w_q.pop_front();
                        chk("wdata", axi.M_AXI_WDATA, w[63:0]);
                        chk("wlast", axi.M_AXI_WLAST, w[64]);
                    end
                end
            end
            stall  = axi.M_AXI_WVALID && !axi.M_AXI_WREADY;
            s_data = axi.M_AXI_WDATA;
            s_last = axi.M_AXI_WLAST;
            if (axi.M_AXI_BVALID && axi.M_AXI_BREADY) outstanding--;
        end
    end

    initial begin
        int h0, n;
        reset = 1'b1; write_req = 1'b0; write_bus_req = 1'b0; wdata = '0; address = '0;
        axi.M_AXI_AWREADY = 1'b1; axi.M_AXI_WREADY = 1'b1; axi.M_AXI_BVALID = 1'b1;
        cyc(); cyc();
        chk("rst_awvalid", axi.M_AXI_AWVALID, 0);
        chk("rst_wvalid", axi.M_AXI_WVALID, 0);
        chk("rst_bready", axi.M_AXI_BREADY, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_awaddr", axi.M_AXI_AWADDR, 0);
        chk("rst_awlen", axi.M_AXI_AWLEN, 0);
        reset = 1'b0;
        cyc();

        // basic 4-beat burst
        for (int i = 1; i <= 4; i++) step(1, 64'(i), 1, 0, 0);
        step(0, 0, 0, 1, 32'h1000);
        wait_done(50);

        // WREADY toggling: stalled beats must hold, exactly 4 handshakes
        h0 = hs_cnt;
        for (int i = 1; i <= 4; i++) step(1, 64'(i), 1, 0, 0);
        axi.M_AXI_WREADY = 1'b1;
        tog = 1;
        step(0, 0, 0, 1, 32'h1100);
        wait_done(50);
        tog = 0;
        axi.M_AXI_WREADY = 1'b1;
        chk("toggle_hs", hs_cnt - h0, 4);

        // overflow: DEPTH+1 pushes, last dropped
        for (int i = 0; i <= DEPTH; i++) step(1, 64'h100 + 64'(i), i < DEPTH, 0, 0);
        chk("ovf_set", overflow, 1);
        step(0, 0, 0, 1, 32'h4000);
        wait_done(100);
        chk("ovf_sticky", overflow, 1);

        // second request while first burst is still in flight, B delayed
        axi.M_AXI_BVALID = 1'b0;
        step(1, 64'h21, 1, 0, 0);
        step(1, 64'h22, 1, 0, 0);
        step(0, 0, 0, 1, 32'h2000);
        cyc();
        step(1, 64'h31, 1, 0, 0);
        step(1, 64'h32, 1, 0, 0);
        step(1, 64'h33, 1, 1, 32'h3000);
        repeat (3) cyc();
        axi.M_AXI_BVALID = 1'b1;
        wait_done(100);

        // request with empty FIFO is discarded
        step(0, 0, 0, 1, 32'h5000);
        for (int i = 0; i < 4; i++) begin
            chk("empty_busy", busy, 0);
            chk("empty_awvalid", axi.M_AXI_AWVALID, 0);
            cyc();
        end

        // reset after 1 of 4 beats aborts the burst and empties the FIFO
        axi.M_AXI_WREADY = 1'b0;
        for (int i = 1; i <= 4; i++) step(1, 64'h40 + 64'(i), 1, 0, 0);
        step(0, 0, 0, 1, 32'h6000);
        n = 0;
        while (!axi.M_AXI_WVALID && n < 20) begin cyc(); n++; end
        chk("wvalid_wait", axi.M_AXI_WVALID, 1);
        axi.M_AXI_WREADY = 1'b1;
        cyc();
        axi.M_AXI_WREADY = 1'b0;
        reset = 1'b1;
        staged.delete();
        cyc();
        chk("mid_awvalid", axi.M_AXI_AWVALID, 0);
        chk("mid_wvalid", axi.M_AXI_WVALID, 0);
        chk("mid_wlast", axi.M_AXI_WLAST, 0);
        chk("mid_bready", axi.M_AXI_BREADY, 0);
        chk("mid_busy", busy, 0);
        chk("mid_ovf", overflow, 0);
        reset = 1'b0;
        axi.M_AXI_WREADY = 1'b1;
        cyc();
        step(1, 64'h55, 1, 0, 0);
        step(0, 0, 0, 1, 32'h7000);
        wait_done(50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_wburst_buf.md
AXI_WBURST_BUF -- requirements
Module: axi_wburst_buf

Interface
REQ-001 Parameter DEPTH, default 32, FIFO depth in 64-bit words; power of two, 2..256.
REQ-002 Block SHALL use one clock and a synchronous, active-high reset.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 write_req  in  1  push wdata into FIFO this cycle.
REQ-006 wdata  in  64  write data word.
REQ-007 write_bus_req  in  1  one-cycle pulse: all words of the current burst have been pushed; start AXI write.
REQ-008 address  in  32  burst start address, sampled with write_bus_req.
REQ-009 busy  out  1  burst pending or in progress.
REQ-010 overflow  out  1  sticky: a push was dropped.
REQ-011 M_AXI_AWADDR out 32; M_AXI_AWLEN out 8; M_AXI_AWSIZE out 3; M_AXI_AWBURST out 2; M_AXI_AWPROT out 3; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1.
REQ-012 M_AXI_WDATA out 64; M_AXI_WSTRB out 8; M_AXI_WLAST out 1; M_AXI_WVALID out 1; M_AXI_WREADY in 1.
REQ-013 M_AXI_BVALID in 1; M_AXI_BREADY out 1.

Function
REQ-014 Constants: AWSIZE=3'b011, AWBURST=2'b01 (INCR), AWPROT=3'b000, WSTRB=8'hFF.
REQ-015 FIFO is first-word-fall-through; WDATA = head word, combinational from storage.
REQ-016 Push: write_req=1 and count<DEPTH -> word stored, count+1 next cycle.
REQ-017 Push when count==DEPTH SHALL be dropped and set overflow, even if a pop occurs same cycle.
REQ-018 Pop: WVALID&WREADY -> head advances, count-1; push+pop same cycle -> count unchanged.
REQ-019 Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
REQ-020 write_bus_req SHALL be captured into a pending flag with address and snapshot count (count after any same-cycle push); snapshot of 0 -> request discarded.
REQ-021 A second write_bus_req while pending is set SHALL be ignored.
REQ-022 FSM states: IDLE, ADDR, DATA, RESP.
REQ-023 IDLE: pending=1 -> ADDR next cycle, clear pending, load beats=snapshot, AWADDR=latched address, AWLEN=snapshot-1.
REQ-024 ADDR: AWVALID=1, AWADDR/AWLEN stable; AWREADY=1 -> DATA.
REQ-025 DATA: WVALID=1; WLAST=1 iff remaining beats==1; each WREADY handshake decrements remaining; handshake with WLAST -> RESP.
REQ-026 RESP: BREADY=1; BVALID=1 -> IDLE; BRESP ignored.
REQ-027 WVALID SHALL be 0 outside DATA; AWVALID 0 outside ADDR; BREADY 0 outside RESP.
REQ-028 Pushes accepted in every state; they belong to the next burst.
REQ-029 busy = (state!=IDLE) | pending.
REQ-030 Minimum latency: write_bus_req at cycle N -> AWVALID at N+2.

Reset
REQ-031 On reset: state=IDLE, pointers/count=0, pending=0, overflow=0; AWVALID, WVALID, WLAST, BREADY, busy = 0; AWADDR, AWLEN = 0.
REQ-032 Reset mid-burst SHALL abort immediately, discard FIFO contents, deassert all valids next cycle; no recovery of the partial burst.

Verification
REQ-033 Push 4 words 0x1..0x4, pulse write_bus_req with address 0x1000, AWREADY/WREADY/BVALID tied 1 -> AWADDR=0x1000, AWLEN=3, WDATA 1,2,3,4 with WLAST on beat 4, busy low after B.
REQ-034 Same with WREADY toggling 1,0,1,0 -> WDATA/WLAST held stable while stalled; exactly 4 handshakes.
REQ-035 Push DEPTH+1 words -> last dropped, overflow=1; burst carries AWLEN=DEPTH-1.
REQ-036 Burst of 2 running while 3 words pushed and second write_bus_req pulsed -> second burst AWLEN=2 follows after BVALID.
REQ-037 write_bus_req with FIFO empty -> no AWVALID, busy stays 0.
REQ-038 reset asserted during DATA after 1 of 4 beats -> next cycle all valids 0, count=0, state IDLE.
